// File: rtl/cpu_uart_pkg.sv
// Shared types and widths for the CPU-side UART word paths.
package cpu_uart_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_MSB,
    ST_WAIT_MSB,
    ST_SEND_LSB,
    ST_WAIT_LSB,
    ST_GAP
  } tx_arb_state_t;

endpackage

// File: rtl/uart_tx_word_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on contention the requester that did not
// win last time is granted; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = '0;
    grant_idx = 1'b0;
    if (valid == 2'b11) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = valid[1];
    end
    if (enable && valid[grant_idx]) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_word_arbiter.sv
// Shares one UART transmitter between two 16-bit word producers, sending
// each granted word MSB byte first, with inter-word gap and per-byte timeout.
module uart_tx_word_arbiter
  import cpu_uart_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [BYTE_W-1:0] TxData,
  output logic              TxStart,
  input  logic              TxBusy,
  input  logic              TxDone,
  output logic              busy,
  output logic              grant_id,
  output logic              err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam tx_arb_state_t POST_WORD = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  tx_arb_state_t     state;
  logic              last_grant;
  logic [BYTE_W-1:0] lsb_byte;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;
  logic [1:0]        grant;
  logic              grant_idx;
  logic              arb_en;
  logic              send_st;
  logic              wait_st;
  logic [WORD_W-1:0] sel_word;

  // Gating with reset keeps both ready strobes low while reset is held.
  assign arb_en = (state == ST_IDLE) && reset;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign send_st     = (state == ST_SEND_MSB) || (state == ST_SEND_LSB);
  assign wait_st     = (state == ST_WAIT_MSB) || (state == ST_WAIT_LSB);
  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign TxStart     = send_st && !TxBusy;
  assign busy        = (state != ST_IDLE);
  // TxDone in the last allowed cycle takes precedence over the timeout.
  assign err_timeout = wait_st && !TxDone && (tcnt == TO_LAST);
  assign sel_word    = grant_idx ? req1_data : req0_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      TxData     <= '0;
      lsb_byte   <= '0;
      tcnt       <= '0;
      gcnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            TxData     <= sel_word[WORD_W-1:BYTE_W];
            lsb_byte   <= sel_word[BYTE_W-1:0];
            grant_id   <= grant_idx;
            last_grant <= grant_idx;
            state      <= ST_SEND_MSB;
          end
        end
        ST_SEND_MSB, ST_SEND_LSB: begin
          if (!TxBusy) begin
            tcnt  <= '0;
            state <= (state == ST_SEND_MSB) ? ST_WAIT_MSB : ST_WAIT_LSB;
          end
        end
        ST_WAIT_MSB, ST_WAIT_LSB: begin
          if (TxDone) begin
            gcnt <= '0;
            if (state == ST_WAIT_MSB) begin
              TxData <= lsb_byte;
              state  <= ST_SEND_LSB;
            end else begin
              state  <= POST_WORD;
            end
          end else if (err_timeout) begin
            gcnt  <= '0;
            state <= POST_WORD;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gcnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Directed bench: dut_a (gap 2, long timeout) and dut_b (gap 0, timeout 8).
module tb_uart_tx_word_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
  logic [15:0] a_req0_data, a_req1_data;
  logic [7:0]  a_TxData;
  logic        a_TxStart, a_TxBusy, a_TxDone, a_busy, a_grant_id, a_err;

  logic        b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [15:0] b_req0_data, b_req1_data;
  logic [7:0]  b_TxData;
  logic        b_TxStart, b_TxBusy, b_TxDone, b_busy, b_grant_id, b_err;

  uart_tx_word_arbiter #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(20000)) dut_a (
    .clk(clk), .reset(rst_n),
    .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_ready(a_req1_ready),
    .TxData(a_TxData), .TxStart(a_TxStart), .TxBusy(a_TxBusy), .TxDone(a_TxDone),
    .busy(a_busy), .grant_id(a_grant_id), .err_timeout(a_err)
  );

  uart_tx_word_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset(rst_n),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .TxData(b_TxData), .TxStart(b_TxStart), .TxBusy(b_TxBusy), .TxDone(b_TxDone),
    .busy(b_busy), .grant_id(b_grant_id), .err_timeout(b_err)
  );

  int checks = 0;
  int failures = 0;
  int a_left0 = 0, a_left1 = 0, a_rdy0 = 0, a_rdy1 = 0, a_starts = 0;
  int b_left0 = 0, b_left1 = 0, b_rdy0 = 0, b_rdy1 = 0, b_errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle of dut_a: inputs change at the falling edge, outputs sampled 1 ns later.
  task automatic cyc_a(input logic done, input logic tx_busy);
    @(negedge clk);
    a_req0_valid = (a_left0 != 0);
    a_req1_valid = (a_left1 != 0);
    a_TxDone = done;
    a_TxBusy = tx_busy;
    #1;
    if (a_req0_ready) begin a_rdy0++; if (a_left0 > 0) a_left0--; end
    if (a_req1_ready) begin a_rdy1++; if (a_left1 > 0) a_left1--; end
    if (a_TxStart) a_starts++;
  endtask

  task automatic cyc_b(input logic done);
    @(negedge clk);
    b_req0_valid = (b_left0 != 0);
    b_req1_valid = (b_left1 != 0);
    b_TxDone = done;
    b_TxBusy = 1'b0;
    #1;
    if (b_req0_ready) begin b_rdy0++; if (b_left0 > 0) b_left0--; end
    if (b_req1_ready) begin b_rdy1++; if (b_left1 > 0) b_left1--; end
    if (b_err) b_errs++;
  endtask

  // Wait (bounded) for a TxStart on dut_a, check the byte, answer TxDone 10 cycles later.
  task automatic byte_a(input string tag, input logic [7:0] exp, input logic gid, output int lat);
    int n = 0;
    cyc_a(1'b0, 1'b0);
    while (!a_TxStart && n < 40) begin
      cyc_a(1'b0, 1'b0);
      n++;
    end
    lat = n;
    chk({tag, "_start"}, 32'(a_TxStart), 1);
    chk({tag, "_data"}, 32'(a_TxData), 32'(exp));
    chk({tag, "_gid"}, 32'(a_grant_id), 32'(gid));
    repeat (9) cyc_a(1'b0, 1'b0);
    cyc_a(1'b1, 1'b0);
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_txdata"}, 32'(a_TxData), 0);
    chk({tag, "_txstart"}, 32'(a_TxStart), 0);
    chk({tag, "_rdy0"}, 32'(a_req0_ready), 0);
    chk({tag, "_rdy1"}, 32'(a_req1_ready), 0);
    chk({tag, "_busy"}, 32'(a_busy), 0);
    chk({tag, "_gid"}, 32'(a_grant_id), 0);
    chk({tag, "_err"}, 32'(a_err), 0);
  endtask

  initial begin
    int lat;
    int s0;
    rst_n = 1'b0;
    a_req0_valid = 1'b0; a_req1_valid = 1'b0; a_req0_data = '0; a_req1_data = '0;
    a_TxBusy = 1'b0; a_TxDone = 1'b0;
    b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_data = '0; b_req1_data = '0;
    b_TxBusy = 1'b0; b_TxDone = 1'b0;

    // Single word, request already pending while reset is held.
    a_left0 = 1; a_req0_data = 16'hA55A; a_req0_valid = 1'b1;
    #2;
    chk_a_zero("rst");
    chk("rst_b_busy", 32'(b_busy), 0);
    #25;
    rst_n = 1'b1;
    cyc_a(1'b0, 1'b0);
    chk("w1_idle_rdy0", 32'(a_req0_ready), 1);
    chk("w1_idle_busy", 32'(a_busy), 0);
    byte_a("w1_msb", 8'hA5, 1'b0, lat);
    chk("w1_msb_latency", lat, 0);
    byte_a("w1_lsb", 8'h5A, 1'b0, lat);
    chk("w1_lsb_latency", lat, 0);
    cyc_a(1'b0, 1'b0); chk("w1_gap1_busy", 32'(a_busy), 1);
    cyc_a(1'b0, 1'b0); chk("w1_gap2_busy", 32'(a_busy), 1);
    cyc_a(1'b0, 1'b0); chk("w1_idle_after", 32'(a_busy), 0);
    chk("w1_ready_pulses", a_rdy0, 1);
    chk("w1_err", 32'(a_err), 0);

    // Contention from reset: grants alternate starting with requester 0.
    @(posedge clk); #2;
    rst_n = 1'b0;
    a_left0 = 3; a_left1 = 3; a_req0_data = 16'h1111; a_req1_data = 16'h2222;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1;
    a_rdy0 = 0; a_rdy1 = 0; a_starts = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      byte_a($sformatf("rr%0d_msb", i), (i % 2 == 0) ? 8'h11 : 8'h22, 1'(i % 2), lat);
      byte_a($sformatf("rr%0d_lsb", i), (i % 2 == 0) ? 8'h11 : 8'h22, 1'(i % 2), lat);
    end
    repeat (4) cyc_a(1'b0, 1'b0);
    chk("rr_rdy0_count", a_rdy0, 3);
    chk("rr_rdy1_count", a_rdy1, 3);
    chk("rr_start_count", a_starts, 12);
    chk("rr_busy_end", 32'(a_busy), 0);

    // TxBusy high for 5 cycles on entry to SEND_MSB.
    a_left0 = 1; a_req0_data = 16'hBEEF;
    cyc_a(1'b0, 1'b0);
    chk("tb_idle_rdy0", 32'(a_req0_ready), 1);
    s0 = a_starts;
    for (int i = 0; i < 5; i++) begin
      cyc_a(1'b0, 1'b1);
      chk($sformatf("tb_hold%0d_start", i), 32'(a_TxStart), 0);
      chk($sformatf("tb_hold%0d_data", i), 32'(a_TxData), 'hBE);
    end
    cyc_a(1'b0, 1'b0);
    chk("tb_release_start", 32'(a_TxStart), 1);
    chk("tb_release_data", 32'(a_TxData), 'hBE);
    repeat (9) cyc_a(1'b0, 1'b0);
    cyc_a(1'b1, 1'b0);
    byte_a("tb_lsb", 8'hEF, 1'b0, lat);
    chk("tb_start_count", a_starts - s0, 2);
    repeat (3) cyc_a(1'b0, 1'b0);

    // Reset during WAIT_LSB, then both pending: requester 0 wins, no partial resend.
    a_left0 = 1; a_req0_data = 16'h1234;
    byte_a("rw_msb", 8'h12, 1'b0, lat);
    cyc_a(1'b0, 1'b0);
    chk("rw_lsb_start", 32'(a_TxStart), 1);
    repeat (3) cyc_a(1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    a_left0 = 1; a_left1 = 1; a_req0_data = 16'h5678; a_req1_data = 16'h9ABC;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1;
    #1;
    chk_a_zero("rw_async");
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc_a(1'b0, 1'b0);
    chk("rs_rdy0", 32'(a_req0_ready), 1);
    chk("rs_rdy1", 32'(a_req1_ready), 0);
    byte_a("rs0_msb", 8'h56, 1'b0, lat);
    byte_a("rs0_lsb", 8'h78, 1'b0, lat);
    byte_a("rs1_msb", 8'h9A, 1'b1, lat);
    byte_a("rs1_lsb", 8'hBC, 1'b1, lat);

    // dut_b: timeout on the MSB, then a TxDone coincident with the timeout cycle.
    b_left0 = 2; b_req0_data = 16'hC3A5;
    cyc_b(1'b0);
    chk("to_idle_rdy0", 32'(b_req0_ready), 1);
    cyc_b(1'b0);
    chk("to_msb_start", 32'(b_TxStart), 1);
    chk("to_msb_data", 32'(b_TxData), 'hC3);
    for (int k = 1; k <= 8; k++) cyc_b(1'b0);
    chk("to_err_pulse", 32'(b_err), 1);
    chk("to_err_count", b_errs, 1);
    cyc_b(1'b0);
    chk("to_after_start", 32'(b_TxStart), 0);
    chk("to_after_busy", 32'(b_busy), 0);
    chk("to_after_rdy0", 32'(b_req0_ready), 1);
    chk("to_after_err", 32'(b_err), 0);
    cyc_b(1'b0);
    chk("co_msb_start", 32'(b_TxStart), 1);
    chk("co_msb_data", 32'(b_TxData), 'hC3);
    for (int k = 1; k <= 7; k++) cyc_b(1'b0);
    cyc_b(1'b1);
    chk("co_no_err", 32'(b_err), 0);
    cyc_b(1'b0);
    chk("co_lsb_start", 32'(b_TxStart), 1);
    chk("co_lsb_data", 32'(b_TxData), 'hA5);
    b_left1 = 1; b_req1_data = 16'h0F0F;
    cyc_b(1'b0);
    cyc_b(1'b0);
    cyc_b(1'b1);
    cyc_b(1'b0);
    chk("g0_idle_busy", 32'(b_busy), 0);
    chk("g0_idle_rdy1", 32'(b_req1_ready), 1);
    cyc_b(1'b0);
    chk("g0_next_start", 32'(b_TxStart), 1);
    chk("g0_next_data", 32'(b_TxData), 'h0F);
    chk("g0_next_gid", 32'(b_grant_id), 1);
    chk("b_err_total", b_errs, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
